// File: rtl/flood_reveal_ctrl_if.sv
// rtl/flood_reveal_ctrl_if.sv - board access port: combinational cell read, registered reveal write
interface flood_reveal_ctrl_if #(
  parameter int N      = 8,
  parameter int CELL_W = 7
);
  localparam int CW = $clog2(N);

  logic [CW-1:0]     rd_i;
  logic [CW-1:0]     rd_j;
  logic [CELL_W-1:0] cell_in;
  logic              wr_we;
  logic [CW-1:0]     wr_i;
  logic [CW-1:0]     wr_j;

  modport master (
    output rd_i, rd_j, wr_we, wr_i, wr_j,
    input  cell_in
  );

  modport slave (
    input  rd_i, rd_j, wr_we, wr_i, wr_j,
    output cell_in
  );
endinterface

// File: rtl/flood_reveal_ctrl.sv
// rtl/flood_reveal_ctrl.sv - stack-based flood reveal sequencer for the minesweeper board
// FLOOD_DIAG_EN: defined selects 8-neighbour expansion, undefined selects 4-neighbour.
module flood_reveal_ctrl #(
  parameter  int N      = 8,
  parameter  int CELL_W = 7,
  localparam int CW     = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CW-1:0]        seed_i,
  input  logic [CW-1:0]        seed_j,
  flood_reveal_ctrl_if.master  board,
  output logic                 busy,
  output logic                 done,
  output logic                 mine_hit,
  output logic [CW*2:0]        revealed_cnt
);

  localparam int AW  = 2 * CW;
  localparam int SPW = 2 * CW + 1;
  localparam int REV_B  = 6;
  localparam int FLG_B  = 5;
  localparam int BOMB_B = 4;
  localparam logic [1:0] M1 = 2'b11;
  localparam logic [1:0] P1 = 2'b01;
`ifdef FLOOD_DIAG_EN
  localparam logic [2:0] K_LAST = 3'd7;
`else
  localparam logic [2:0] K_LAST = 3'd3;
`endif

  typedef enum logic [2:0] {S_IDLE, S_POP, S_EVAL, S_NEIGH, S_DONE} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   stack [N*N];
  logic [SPW-1:0]  sp;
  logic [N*N-1:0]  visited;
  logic [2:0]      k;
  logic            first;
  logic            mine_hit_pend;

  logic            do_load, do_pop, do_reveal, do_push;
  logic [1:0]      di, dj;
  logic [CW:0]     ni_ext, nj_ext;
  logic            nb_oob;
  logic [AW-1:0]   nb_idx;
  logic [AW-1:0]   top_idx;
  logic            c_rev, c_flg, c_bomb;
  logic [3:0]      c_cnt;

  assign c_rev   = board.cell_in[REV_B];
  assign c_flg   = board.cell_in[FLG_B];
  assign c_bomb  = board.cell_in[BOMB_B];
  assign c_cnt   = board.cell_in[3:0];
  // Low bits suffice: sp never exceeds N*N, and sp==N*N wraps to index N*N-1.
  assign top_idx = sp[AW-1:0] - 1'b1;

  // Neighbour offsets, clockwise from "up".
  always_comb begin
    di = 2'b00;
    dj = 2'b00;
`ifdef FLOOD_DIAG_EN
    case (k)
      3'd0: di = M1;
      3'd1: begin di = M1; dj = P1; end
      3'd2: dj = P1;
      3'd3: begin di = P1; dj = P1; end
      3'd4: di = P1;
      3'd5: begin di = P1; dj = M1; end
      3'd6: dj = M1;
      default: begin di = M1; dj = M1; end
    endcase
`else
    case (k)
      3'd0: di = M1;
      3'd1: dj = P1;
      3'd2: di = P1;
      3'd3: dj = M1;
      default: ;
    endcase
`endif
  end

  // Board is a power of two, so stepping off either edge sets the carry bit.
  assign ni_ext = {1'b0, board.rd_i} + {{(CW-1){di[1]}}, di};
  assign nj_ext = {1'b0, board.rd_j} + {{(CW-1){dj[1]}}, dj};
  assign nb_oob = ni_ext[CW] | nj_ext[CW];
  assign nb_idx = {ni_ext[CW-1:0], nj_ext[CW-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    do_load   = 1'b0;
    do_pop    = 1'b0;
    do_reveal = 1'b0;
    do_push   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          do_load  = 1'b1;
          state_nx = S_POP;
        end
      end
      S_POP: begin
        if (sp == '0) begin
          state_nx = S_DONE;
        end else begin
          do_pop   = 1'b1;
          state_nx = S_EVAL;
        end
      end
      S_EVAL: begin
        state_nx = S_POP;
        if (!(c_flg || c_rev) && !c_bomb) begin
          do_reveal = 1'b1;
          if (c_cnt == 4'd0) state_nx = S_NEIGH;
        end
      end
      S_NEIGH: begin
        do_push = !nb_oob && !visited[nb_idx];
        if (k == K_LAST) state_nx = S_POP;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp            <= '0;
      visited       <= '0;
      k             <= '0;
      first         <= 1'b0;
      mine_hit_pend <= 1'b0;
      revealed_cnt  <= '0;
      board.rd_i    <= '0;
      board.rd_j    <= '0;
      board.wr_i    <= '0;
      board.wr_j    <= '0;
      board.wr_we   <= 1'b0;
    end else begin
      board.wr_we <= do_reveal;
      if (do_load) begin
        visited                   <= '0;
        visited[{seed_i, seed_j}] <= 1'b1;
        sp                        <= SPW'(1);
        revealed_cnt              <= '0;
        first                     <= 1'b0;
      end
      if (do_pop) begin
        sp                         <= sp - 1'b1;
        {board.rd_i, board.rd_j}   <= stack[top_idx];
      end
      if (state == S_EVAL) begin
        first <= 1'b1;
        k     <= '0;
        if (!(c_flg || c_rev) && c_bomb && !first) mine_hit_pend <= 1'b1;
      end
      if (do_reveal) begin
        board.wr_i   <= board.rd_i;
        board.wr_j   <= board.rd_j;
        revealed_cnt <= revealed_cnt + 1'b1;
      end
      if (state == S_NEIGH) k <= k + 1'b1;
      if (do_push) begin
        visited[nb_idx] <= 1'b1;
        sp              <= sp + 1'b1;
      end
      if (state == S_DONE) mine_hit_pend <= 1'b0;
    end
  end

  // Coordinate stack storage; contents are don't-care while sp is zero.
  always_ff @(posedge clk) begin
    if (do_load)      stack[0]            <= {seed_i, seed_j};
    else if (do_push) stack[sp[AW-1:0]]   <= nb_idx;
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign mine_hit = (state == S_DONE) && mine_hit_pend;

endmodule

// File: doc/flood_reveal_ctrl.md
# flood_reveal_ctrl

Sequencer that uncovers a connected region of the minesweeper board after a cell is selected. Given a seed coordinate, it walks the board with an explicit coordinate stack and a visited bitmap. It reveals every reachable non-bomb, non-flagged cell, and expands through cells whose adjacent-mine count is zero. It sits between the game FSM (start/done handshake) and the board register (one combinational read port, one registered reveal-write port).

## Interface
- `N`, default 8: board dimension per axis (power of two); coordinate width `CW = $clog2(N)`.
- `CELL_W`, default 7: board cell width. Cell fields: bit6 revealed, bit5 flagged, bit4 bomb, bits3:0 adjacent-mine count.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request; sampled only in IDLE.
- `seed_i`, `seed_j`, in, CW each: selected cell row and column.
- `rd_i`, `rd_j`, out, CW each: registered read address to the board.
- `cell_in`, in, CELL_W: board cell at (`rd_i`, `rd_j`), combinational, valid in the same cycle.
- `wr_we`, out, 1: registered one-cycle pulse meaning "set revealed bit" at (`wr_i`, `wr_j`).
- `wr_i`, `wr_j`, out, CW each: reveal-write address.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of every request.
- `mine_hit`, out, 1: pulses together with `done` when the seed cell is a bomb.
- `revealed_cnt`, out, CW*2+1: number of reveal writes issued by the current or last request.

## Operation
- States: IDLE, POP, EVAL, NEIGH, DONE.
- IDLE:
  - On `start`: clear the 64-bit visited map, then set the seed's bit.
  - Write `stack[0]` = seed, set `sp` = 1, clear `revealed_cnt`, clear `first`.
  - Go to POP.
- POP:
  - `sp == 0`: go to DONE.
  - Otherwise: `sp--`, set `rd_i`/`rd_j` to `stack[sp-1]`, go to EVAL.
- EVAL evaluates `cell_in`, checked in this order:
  - Flagged or revealed: no write; go to POP.
  - Bomb: no write. If this is the seed cell (`first` clear), latch `mine_hit_pend`. Go to POP.
  - Otherwise: next cycle `wr_we` = 1 with `wr_i`/`wr_j` = `rd_i`/`rd_j`, and `revealed_cnt++`. Go to NEIGH if count == 0, else POP.
  - In every case, EVAL sets `first`.
- NEIGH:
  - Neighbour index `k` steps one per cycle over 8 offsets (4 without the macro), starting at k=0 = (-1,0) and proceeding clockwise.
  - Skip a neighbour if it is out of bounds (no wrap-around at edges) or already visited.
  - Otherwise push it and mark it visited.
  - After the last `k`, go to POP.
- DONE: `done` = 1, `mine_hit` = `mine_hit_pend`, then go to IDLE and clear `mine_hit_pend`.
- Stack depth N*N. Overflow is impossible because each cell is pushed at most once, so no full flag exists.
- `start` while busy is ignored; it is not queued.
- Board changes made by other writers during a flood are seen only at that cell's EVAL.

## Timing
- Reset values: state IDLE; `busy` 0, `done` 0, `mine_hit` 0, `wr_we` 0; `wr_i`/`wr_j`/`rd_i`/`rd_j` 0; `revealed_cnt` 0; `sp` 0.
- Reset asserted mid-flood returns to IDLE immediately (asynchronous). No further `wr_we` is issued and no `done` pulse is produced.
- Single non-zero cell, `start` sampled at edge E0:
  - E0: POP.
  - E1: EVAL.
  - `wr_we` is high between E2 and E3.
  - `done` is high between E3 and E4.
  - `busy` falls after E4.
- Busy cycles = 2 + Σ(2 per popped entry) + (8, or 4 without the macro, per zero-count cell revealed).
- `wr_we` never occurs in two consecutive cycles.
- `revealed_cnt` is stable from DONE until the next accepted `start`.

## Configuration
- `FLOOD_DIAG_EN`:
  - Defined: 8-neighbour expansion (orthogonal + diagonal); NEIGH lasts 8 cycles.
  - Undefined: 4-neighbour expansion (up, right, down, left); NEIGH lasts 4 cycles and the diagonal offset logic is not compiled.

## Test plan
- Reset with `rst`=0 mid-idle and mid-flood -> all outputs at reset values; no `wr_we` after reset edge; next `start` works normally.
- Seed (2,5) with count 3, nothing else -> exactly one `wr_we` at (2,5); `revealed_cnt`=1; `done` 3 cycles after `start` sample; `mine_hit`=0.
- Seed on flagged cell -> zero writes, `revealed_cnt`=0, `done` pulse, `mine_hit`=0. Seed on bomb -> zero writes, `done` and `mine_hit` pulse together.
- Single bomb at (7,7) (correct counts), seed (0,0), macro on -> 63 distinct writes, never (7,7), `revealed_cnt`=63, no address written twice.
- Empty board (all counts 0), seed (3,3) -> 64 writes. Busy lasts 642 cycles with `FLOOD_DIAG_EN`, 386 without.
- `start` pulsed while busy with seed (0,0) -> ignored; the result matches the original request only.
